// File: rtl/lis3dh_ctrl.sv
// LIS3DH command sequencer: boot wait, register config, WHO_AM_I check,
// then periodic X/Y/Z reads published as one atomic sample set.
module lis3dh_ctrl #(
    parameter int unsigned BOOT_CYCLES    = 50000,
    parameter int unsigned SAMPLE_CYCLES  = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  CTRL_REG1_VAL  = 8'h57,
    parameter logic [7:0]  CTRL_REG4_VAL  = 8'h88,
    parameter logic [7:0]  WHO_AM_I_VAL   = 8'h33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               spi_done,
    input  logic [15:0]        spi_data_rx,
    output logic [23:0]        spi_data_tx,
    output logic               spi_data_tx_valid,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic               sample_valid,
    output logic               config_done,
    output logic               id_err,
    output logic               timeout_err
);
    localparam int unsigned CMAX =
        (BOOT_CYCLES > SAMPLE_CYCLES) ? BOOT_CYCLES : SAMPLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
    localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_BOOT, S_CFG1, S_CFG4, S_CHK_ID, S_IDLE,
        S_RD_X, S_RD_Y, S_RD_Z, S_PUBLISH, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          wait_q, wait_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q;
    logic          done_rise;
    logic [23:0]   tx_q, tx_d;
    logic          tx_valid_q, tx_valid_d;
    logic [15:0]   sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_z_q, sh_z_d;
    logic [15:0]   ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic          sample_valid_q, sample_valid_d;
    logic          config_done_q, config_done_d;
    logic          id_err_q, id_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic [15:0]   rx_swap;

    function automatic logic [23:0] frame_of(state_t s);
        case (s)
            S_CFG1:   return {2'b00, 6'h20, CTRL_REG1_VAL, 8'h00};
            S_CFG4:   return {2'b00, 6'h23, CTRL_REG4_VAL, 8'h00};
            S_CHK_ID: return {2'b11, 6'h0F, 16'h0000};
            S_RD_X:   return {2'b11, 6'h28, 16'h0000};
            S_RD_Y:   return {2'b11, 6'h2A, 16'h0000};
            S_RD_Z:   return {2'b11, 6'h2C, 16'h0000};
            default:  return 24'h000000;
        endcase
    endfunction

    // Only a fresh 0->1 of spi_done completes a frame
    assign done_rise = spi_done & ~done_q;
    assign rx_swap   = {spi_data_rx[7:0], spi_data_rx[15:8]};

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        tx_d           = tx_q;
        tx_valid_d     = 1'b0;
        sh_x_d         = sh_x_q;
        sh_y_d         = sh_y_q;
        sh_z_d         = sh_z_q;
        ax_d           = ax_q;
        ay_d           = ay_q;
        az_d           = az_q;
        sample_valid_d = 1'b0;
        config_done_d  = config_done_q;
        id_err_d       = id_err_q;
        timeout_err_d  = timeout_err_q;
        unique case (state_q)
            S_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = S_CFG1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (cnt_q < SAMP_LAST) cnt_d = cnt_q + 1'b1;
                if (enable && cnt_q >= SAMP_LAST) state_d = S_RD_X;
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
                if (cnt_q < SAMP_LAST) cnt_d = cnt_q + 1'b1;
            end
            S_ERROR: ;
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                    tmo_d  = '0;
                end else if (done_rise) begin
                    wait_d = 1'b0;
                    case (state_q)
                        S_CFG1: state_d = S_CFG4;
                        S_CFG4: state_d = S_CHK_ID;
                        S_CHK_ID: begin
                            if (spi_data_rx[15:8] == WHO_AM_I_VAL) begin
                                config_done_d = 1'b1;
                                state_d       = S_IDLE;
                                cnt_d         = '0;
                            end else begin
                                id_err_d = 1'b1;
                                state_d  = S_ERROR;
                            end
                        end
                        S_RD_X: begin
                            sh_x_d  = rx_swap;
                            state_d = S_RD_Y;
                        end
                        S_RD_Y: begin
                            sh_y_d  = rx_swap;
                            state_d = S_RD_Z;
                        end
                        S_RD_Z: begin
                            sh_z_d  = rx_swap;
                            state_d = S_PUBLISH;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    wait_d        = 1'b0;
                    state_d       = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
        // Frame and strobe are registered together on entry to ISSUE
        if (state_d != state_q && state_d inside
            {S_CFG1, S_CFG4, S_CHK_ID, S_RD_X, S_RD_Y, S_RD_Z}) begin
            tx_d       = frame_of(state_d);
            tx_valid_d = 1'b1;
        end
        if (state_d == S_PUBLISH) begin
            ax_d           = sh_x_d;
            ay_d           = sh_y_d;
            az_d           = sh_z_d;
            sample_valid_d = 1'b1;
        end
        if (state_d == S_ERROR) config_done_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_BOOT;
            wait_q         <= 1'b0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            done_q         <= 1'b0;
            tx_q           <= '0;
            tx_valid_q     <= 1'b0;
            sh_x_q         <= '0;
            sh_y_q         <= '0;
            sh_z_q         <= '0;
            ax_q           <= '0;
            ay_q           <= '0;
            az_q           <= '0;
            sample_valid_q <= 1'b0;
            config_done_q  <= 1'b0;
            id_err_q       <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            done_q         <= spi_done;
            tx_q           <= tx_d;
            tx_valid_q     <= tx_valid_d;
            sh_x_q         <= sh_x_d;
            sh_y_q         <= sh_y_d;
            sh_z_q         <= sh_z_d;
            ax_q           <= ax_d;
            ay_q           <= ay_d;
            az_q           <= az_d;
            sample_valid_q <= sample_valid_d;
            config_done_q  <= config_done_d;
            id_err_q       <= id_err_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign spi_data_tx       = tx_q;
    assign spi_data_tx_valid = tx_valid_q;
    assign accel_x           = ax_q;
    assign accel_y           = ay_q;
    assign accel_z           = az_q;
    assign sample_valid      = sample_valid_q;
    assign config_done       = config_done_q;
    assign id_err            = id_err_q;
    assign timeout_err       = timeout_err_q;
endmodule

// File: tb/tb_lis3dh_ctrl.sv
// Scoreboard bench for lis3dh_ctrl: SPI responder model, expected frame
// and sample queues, and a monitor comparing everything the DUT presents.
`timescale 1ns/1ps
module tb_lis3dh_ctrl;
    localparam int BOOT = 16;
    localparam int SAMP = 500;
    localparam int TMO  = 64;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               spi_done;
    logic [15:0]        spi_data_rx;
    logic [23:0]        spi_data_tx;
    logic               spi_data_tx_valid;
    logic signed [15:0] accel_x, accel_y, accel_z;
    logic               sample_valid, config_done, id_err, timeout_err;

    lis3dh_ctrl #(
        .BOOT_CYCLES(BOOT),
        .SAMPLE_CYCLES(SAMP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .spi_done(spi_done),
        .spi_data_rx(spi_data_rx),
        .spi_data_tx(spi_data_tx),
        .spi_data_tx_valid(spi_data_tx_valid),
        .accel_x(accel_x),
        .accel_y(accel_y),
        .accel_z(accel_z),
        .sample_valid(sample_valid),
        .config_done(config_done),
        .id_err(id_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_frames[$];
    logic [47:0] exp_samples[$];
    logic [15:0] rx_x_q[$], rx_y_q[$], rx_z_q[$];
    logic [15:0] id_rx = 16'h3300;
    bit          stall_y = 0;
    bit          chk_period = 0;
    int          hold_len = 5;

    int          n_frames = 0, n_samples = 0;
    int          rel_cyc = 0, pub_cyc = 0, ea_cyc = 0, last_frame_cyc = 0;
    bit          period_armed = 0;
    logic [47:0] last_pub = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name, logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing at cycle %0d",
                 name, act, cyc);
    endtask

    function automatic logic [15:0] le16(logic [15:0] rx);
        return {rx[7:0], rx[15:8]};
    endfunction

    // SPI master model: answers each frame after a delay, holds done high
    initial begin
        int dly;
        int hold;
        bit busy;
        logic [15:0] pend;
        logic [5:0] addr;
        spi_done = 1'b0;
        spi_data_rx = '0;
        dly = 0;
        hold = 0;
        busy = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0;
                hold = 0;
                spi_done = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) spi_done = 1'b0;
                end
                if (busy) begin
                    if (dly == 0) begin
                        busy = 0;
                        spi_data_rx = pend;
                        spi_done = 1'b1;
                        hold = hold_len;
                    end else begin
                        dly--;
                    end
                end
                if (spi_data_tx_valid) begin
                    addr = spi_data_tx[21:16];
                    pend = 16'h0000;
                    if (addr == 6'h0F) pend = id_rx;
                    if (addr == 6'h28 && rx_x_q.size() > 0) pend = rx_x_q.pop_front();
                    if (addr == 6'h2A && rx_y_q.size() > 0) pend = rx_y_q.pop_front();
                    if (addr == 6'h2C && rx_z_q.size() > 0) pend = rx_z_q.pop_front();
                    if (!(stall_y && addr == 6'h2A)) begin
                        busy = 1;
                        dly = $urandom_range(8, 40);
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a frame or sample
    initial begin
        logic [23:0] ef;
        logic [47:0] es;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_frames = 0;
                n_samples = 0;
                last_pub = '0;
                period_armed = 0;
            end else begin
                if (spi_data_tx_valid) begin
                    n_frames++;
                    last_frame_cyc = cyc;
                    if (n_frames == 1)
                        check("first_frame_cycle", cyc - rel_cyc, BOOT);
                    if (exp_frames.size() == 0) begin
                        fail_now("unexpected_frame", spi_data_tx);
                    end else begin
                        ef = exp_frames.pop_front();
                        check("frame", spi_data_tx, ef);
                    end
                    if (spi_data_tx == 24'hE80000 && period_armed) begin
                        check("period", cyc - pub_cyc, SAMP);
                        period_armed = 0;
                    end
                    if (spi_data_tx == 24'hEA0000) ea_cyc = cyc;
                end
                if (sample_valid) begin
                    n_samples++;
                    pub_cyc = cyc;
                    period_armed = chk_period;
                    if (exp_samples.size() == 0) begin
                        fail_now("unexpected_sample", {accel_x, accel_y, accel_z});
                        last_pub = {accel_x, accel_y, accel_z};
                    end else begin
                        es = exp_samples.pop_front();
                        check("sample_xyz", {accel_x, accel_y, accel_z}, es);
                        last_pub = es;
                    end
                end else begin
                    check("accel_stable", {accel_x, accel_y, accel_z}, last_pub);
                end
            end
        end
    end

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_frames.delete();
        exp_samples.delete();
        rx_x_q.delete();
        rx_y_q.delete();
        rx_z_q.delete();
        chk_period = 0;
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic push_cfg();
        exp_frames.push_back(24'h205700);
        exp_frames.push_back(24'h238800);
        exp_frames.push_back(24'hCF0000);
    endtask

    task automatic push_set(logic [15:0] x, logic [15:0] y, logic [15:0] z,
                            bit complete);
        exp_frames.push_back(24'hE80000);
        exp_frames.push_back(24'hEA0000);
        rx_x_q.push_back(x);
        rx_y_q.push_back(y);
        rx_z_q.push_back(z);
        if (complete) begin
            exp_frames.push_back(24'hEC0000);
            exp_samples.push_back({le16(x), le16(y), le16(z)});
        end
    endtask

    task automatic wait_frames(int n, int bound, string name);
        int k = 0;
        while (n_frames < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, n_frames >= n, 1);
    endtask

    task automatic wait_samples(int n, int bound, string name);
        int k = 0;
        while (n_samples < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, n_samples >= n, 1);
    endtask

    task automatic wait_cfg(int bound);
        int k = 0;
        while (!config_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("config_done_rise", config_done, 1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cyc;
        int k;
        int d;
        logic [15:0] rx;

        // Scenario 1: config, enable gating, periodic sampling
        assert_reset();
        check("reset_outputs",
              {spi_data_tx, spi_data_tx_valid, accel_x, accel_y, accel_z,
               sample_valid, config_done, id_err, timeout_err}, '0);
        id_rx = {8'h33, 8'($urandom)};
        stall_y = 0;
        hold_len = 5;
        enable = 1'b0;
        push_cfg();
        release_reset();
        wait_cfg(1000);
        check("cfg_frames", n_frames, 3);
        check("cfg_id_err", id_err, 0);
        push_set(16'h3412, 16'hFF80, 16'h0040, 1);
        for (int s = 0; s < 3; s++)
            push_set(16'($urandom), 16'($urandom), 16'($urandom), 1);
        repeat (1500) @(negedge clk);
        check("disabled_no_frames", n_frames, 3);
        enable = 1'b1;
        en_cyc = cyc;
        chk_period = 1;
        wait_frames(4, 10, "wait_rdx_after_enable");
        check("enable_to_rdx", last_frame_cyc - en_cyc, 1);
        wait_samples(3, 5000, "wait_three_sets");
        wait_frames(14, 2000, "wait_last_rdy");
        enable = 1'b0;
        wait_samples(4, 2000, "wait_last_set");
        repeat (1500) @(negedge clk);
        check("paused_frames", n_frames, 15);
        check("paused_samples", n_samples, 4);
        check("s1_frames_left", exp_frames.size(), 0);
        check("s1_samples_left", exp_samples.size(), 0);
        check("s1_flags", {config_done, id_err, timeout_err}, 3'b100);

        // Scenario 2: WHO_AM_I mismatch
        assert_reset();
        id_rx = 16'h3200;
        enable = 1'b1;
        push_cfg();
        release_reset();
        wait_frames(3, 1000, "wait_id_frames");
        repeat (10000) @(negedge clk);
        check("id_err_set", id_err, 1);
        check("id_cfg_done", config_done, 0);
        check("id_tmo", timeout_err, 0);
        check("id_frames", n_frames, 3);
        check("id_frames_left", exp_frames.size(), 0);

        // Scenario 3: no answer on RD_Y
        assert_reset();
        id_rx = 16'h3300;
        stall_y = 1;
        enable = 1'b1;
        push_cfg();
        push_set(16'($urandom), 16'($urandom), 16'($urandom), 0);
        release_reset();
        wait_cfg(1000);
        k = 0;
        while (!timeout_err && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_set", timeout_err, 1);
        d = cyc - ea_cyc;
        check("timeout_delay", (d == TMO || d == TMO + 1), 1);
        repeat (200) @(negedge clk);
        check("tmo_accel", {accel_x, accel_y, accel_z}, '0);
        check("tmo_samples", n_samples, 0);
        check("tmo_frames", n_frames, 5);
        check("tmo_flags", {config_done, id_err}, 2'b00);

        // Scenario 4: reset in the middle of the RD_Y wait
        assert_reset();
        push_cfg();
        push_set(16'($urandom), 16'($urandom), 16'($urandom), 0);
        release_reset();
        wait_frames(5, 2000, "wait_rdy_issue");
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_outputs",
              {spi_data_tx, spi_data_tx_valid, accel_x, accel_y, accel_z,
               sample_valid, config_done, id_err, timeout_err}, '0);
        exp_frames.delete();
        rx_x_q.delete();
        rx_y_q.delete();
        rx_z_q.delete();
        stall_y = 0;
        push_cfg();
        rx = 16'($urandom);
        push_set(rx, 16'($urandom), 16'($urandom), 1);
        release_reset();
        wait_cfg(1000);
        check("restart_frames", n_frames, 3);
        wait_samples(1, 2000, "restart_sample");
        check("restart_frames_left", exp_frames.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
